// File: rtl/inst_rom_ctrl_pkg.sv
// Shared bus widths, NOP encoding and FSM state type for the instruction ROM controller.
package inst_rom_ctrl_pkg;

  localparam int unsigned REG_BUS_W       = 32;
  localparam int unsigned INST_BUS_W      = 32;
  localparam int unsigned INST_ADDR_BUS_W = 32;

  localparam logic [INST_BUS_W-1:0] NOP_INST = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } rom_state_e;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/inst_rom_ctrl_if.sv
// Program-load stream: loader (master) pushes words, ROM controller (slave) accepts.
interface inst_rom_ctrl_if;
  import inst_rom_ctrl_pkg::*;

  logic                 load_start_i;
  logic                 load_valid_i;
  logic [REG_BUS_W-1:0] load_data_i;
  logic                 load_last_i;
  logic                 load_ready_o;

  modport master (
    output load_start_i,
    output load_valid_i,
    output load_data_i,
    output load_last_i,
    input  load_ready_o
  );

  modport slave (
    input  load_start_i,
    input  load_valid_i,
    input  load_data_i,
    input  load_last_i,
    output load_ready_o
  );

endinterface

// File: rtl/inst_rom_mem.sv
// Instruction storage: one synchronous write port, one asynchronous read port, no reset.
module inst_rom_mem #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_ctrl.sv
// Instruction ROM controller: loads a program over a valid/ready stream, then serves CPU fetches.
// Optional fetch misalignment flag is built only when INST_ROM_MISALIGN_CHK_EN is defined.
module inst_rom_ctrl
  import inst_rom_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rom_ce_i,
  input  logic [INST_ADDR_BUS_W-1:0] rom_addr_i,
  output logic [INST_BUS_W-1:0]      rom_data_o,
  output logic                       cpu_rst_o,
  inst_rom_ctrl_if.slave             ld,
  output logic [ADDR_W:0]            word_cnt_o,
  output logic                       load_ovf_o,
  output logic                       fetch_misalign_o
);

  localparam logic [ADDR_W-1:0] PTR_MAX = '1;

  rom_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    ptr_q, ptr_d;
  logic [ADDR_W:0]      cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 cpu_rst_q;
  logic                 accept;
  logic                 fetch_hit;
  logic [INST_BUS_W-1:0] mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      // Registered from the current state, so release/reassert lags RUN by one cycle.
      cpu_rst_q <= (state_q != ST_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (ld.load_start_i) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld.load_start_i) begin
          // Restart wins over a same-cycle word, which is dropped.
          ptr_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (ld.load_valid_i) begin
          accept = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (ld.load_last_i) begin
            state_d = ST_RUN;
          end
          if (ptr_q == PTR_MAX) begin
            state_d = ST_RUN;
            ovf_d   = ~ld.load_last_i;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  inst_rom_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (INST_BUS_W)
  ) u_mem (
    .clk   (clk),
    .we    (accept),
    .waddr (ptr_q),
    .wdata (ld.load_data_i),
    .raddr (rom_addr_i[ADDR_W+1:2]),
    .rdata (mem_rdata)
  );

  assign fetch_hit = (state_q == ST_RUN) && rom_ce_i &&
                     (rom_addr_i[INST_ADDR_BUS_W-1:ADDR_W+2] == '0);

  assign rom_data_o      = fetch_hit ? mem_rdata : NOP_INST;
  assign cpu_rst_o       = cpu_rst_q;
  assign ld.load_ready_o = (state_q == ST_LOAD);
  assign word_cnt_o      = cnt_q;
  assign load_ovf_o      = ovf_q;

`ifdef INST_ROM_MISALIGN_CHK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (ld.load_start_i) begin
      misalign_q <= 1'b0;
    end else if ((state_q == ST_RUN) && rom_ce_i && !is_word_aligned(rom_addr_i[1:0])) begin
      misalign_q <= 1'b1;
    end
  end

  assign fetch_misalign_o = misalign_q;
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb  = ^rom_addr_i[1:0];
  assign fetch_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Directed bench for inst_rom_ctrl: vector table on a default-depth instance plus
// hand sequences for reset mid-load, misalignment and overflow on a 4-word instance.
module tb_inst_rom_ctrl;

  typedef struct {
    logic        start;
    logic        valid;
    logic        last;
    logic [31:0] data;
    logic        ce;
    logic [31:0] addr;
    logic [10:0] cnt;
    logic        rdy;
    logic        crst;
    logic        ovf;
    logic [31:0] dout;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

`ifdef INST_ROM_MISALIGN_CHK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif

  // Default-depth instance
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] dout;
  logic        crst;
  logic [10:0] cnt;
  logic        ovf;
  logic        mis;
  inst_rom_ctrl_if ld ();

  inst_rom_ctrl #(.ADDR_W(10)) dut (
    .clk              (clk),
    .rst              (rst),
    .rom_ce_i         (ce),
    .rom_addr_i       (addr),
    .rom_data_o       (dout),
    .cpu_rst_o        (crst),
    .ld               (ld.slave),
    .word_cnt_o       (cnt),
    .load_ovf_o       (ovf),
    .fetch_misalign_o (mis)
  );

  // Four-word instance for overflow
  logic        rst2;
  logic        ce2;
  logic [31:0] addr2;
  logic [31:0] dout2;
  logic        crst2;
  logic [2:0]  cnt2;
  logic        ovf2;
  logic        mis2;
  inst_rom_ctrl_if ld2 ();

  inst_rom_ctrl #(.ADDR_W(2)) dut2 (
    .clk              (clk),
    .rst              (rst2),
    .rom_ce_i         (ce2),
    .rom_addr_i       (addr2),
    .rom_data_o       (dout2),
    .cpu_rst_o        (crst2),
    .ld               (ld2.slave),
    .word_cnt_o       (cnt2),
    .load_ovf_o       (ovf2),
    .fetch_misalign_o (mis2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic va, input logic la,
                              input logic [31:0] d, input logic c, input logic [31:0] a,
                              input logic [10:0] ec, input logic er, input logic ecr,
                              input logic eo, input logic [31:0] ed);
    vec_t v;
    v.start = st; v.valid = va; v.last = la; v.data = d; v.ce = c; v.addr = a;
    v.cnt = ec; v.rdy = er; v.crst = ecr; v.ovf = eo; v.dout = ed;
    return v;
  endfunction

  task automatic drive(input logic st, input logic va, input logic la, input logic [31:0] d,
                       input logic c, input logic [31:0] a);
    ld.load_start_i = st;
    ld.load_valid_i = va;
    ld.load_last_i  = la;
    ld.load_data_i  = d;
    ce              = c;
    addr            = a;
  endtask

  task automatic drive2(input logic st, input logic va, input logic la, input logic [31:0] d,
                        input logic c, input logic [31:0] a);
    ld2.load_start_i = st;
    ld2.load_valid_i = va;
    ld2.load_last_i  = la;
    ld2.load_data_i  = d;
    ce2              = c;
    addr2            = a;
  endtask

  vec_t tbl [24];

  initial begin
    //          st va la data          ce addr     | cnt rdy crst ovf dout
    tbl[0]  = mk(1, 0, 0, 32'h0,        1, 32'h8,    0, 1, 1, 0, 32'h0);
    tbl[1]  = mk(0, 1, 0, 32'h34010001, 1, 32'h8,    1, 1, 1, 0, 32'h0);
    tbl[2]  = mk(0, 1, 0, 32'h34010002, 1, 32'h8,    2, 1, 1, 0, 32'h0);
    tbl[3]  = mk(0, 1, 0, 32'h34010003, 1, 32'h8,    3, 1, 1, 0, 32'h0);
    tbl[4]  = mk(0, 1, 1, 32'h34010004, 1, 32'h8,    4, 0, 1, 0, 32'h34010003);
    tbl[5]  = mk(0, 0, 0, 32'h0,        1, 32'h8,    4, 0, 0, 0, 32'h34010003);
    tbl[6]  = mk(0, 0, 0, 32'h0,        1, 32'h0,    4, 0, 0, 0, 32'h34010001);
    tbl[7]  = mk(0, 0, 0, 32'h0,        0, 32'h0,    4, 0, 0, 0, 32'h0);
    tbl[8]  = mk(0, 0, 0, 32'h0,        1, 32'h1000, 4, 0, 0, 0, 32'h0);
    tbl[9]  = mk(0, 0, 0, 32'h0,        1, 32'hC,    4, 0, 0, 0, 32'h34010004);
    tbl[10] = mk(1, 0, 0, 32'h0,        1, 32'h0,    0, 1, 0, 0, 32'h0);
    tbl[11] = mk(0, 0, 0, 32'h0,        1, 32'h0,    0, 1, 1, 0, 32'h0);
    tbl[12] = mk(0, 1, 0, 32'hA0000001, 1, 32'h4,    1, 1, 1, 0, 32'h0);
    tbl[13] = mk(0, 0, 0, 32'hDEAD0000, 1, 32'h4,    1, 1, 1, 0, 32'h0);
    tbl[14] = mk(0, 1, 0, 32'hA0000002, 1, 32'h4,    2, 1, 1, 0, 32'h0);
    tbl[15] = mk(0, 0, 1, 32'hDEAD0001, 1, 32'h4,    2, 1, 1, 0, 32'h0);
    tbl[16] = mk(0, 1, 1, 32'hA0000003, 1, 32'h4,    3, 0, 1, 0, 32'hA0000002);
    tbl[17] = mk(0, 0, 0, 32'h0,        1, 32'h8,    3, 0, 0, 0, 32'hA0000003);
    tbl[18] = mk(0, 0, 0, 32'h0,        1, 32'hC,    3, 0, 0, 0, 32'h34010004);
    tbl[19] = mk(1, 0, 0, 32'h0,        1, 32'h0,    0, 1, 0, 0, 32'h0);
    tbl[20] = mk(0, 1, 0, 32'h11111111, 1, 32'h0,    1, 1, 1, 0, 32'h0);
    tbl[21] = mk(1, 1, 0, 32'h22222222, 1, 32'h0,    0, 1, 1, 0, 32'h0);
    tbl[22] = mk(0, 1, 1, 32'h33333333, 1, 32'h0,    1, 0, 1, 0, 32'h33333333);
    tbl[23] = mk(0, 0, 0, 32'h0,        1, 32'h4,    1, 0, 0, 0, 32'hA0000002);

    rst  = 1'b1;
    rst2 = 1'b1;
    drive(0, 0, 0, 32'h0, 1, 32'h0);
    drive2(0, 0, 0, 32'h0, 1, 32'h0);
    step();

    chk("rst.cnt",  32'(cnt),  32'h0);
    chk("rst.rdy",  32'(ld.load_ready_o), 32'h0);
    chk("rst.crst", 32'(crst), 32'h1);
    chk("rst.ovf",  32'(ovf),  32'h0);
    chk("rst.mis",  32'(mis),  32'h0);
    chk("rst.dout", dout,      32'h0);
    rst = 1'b0;
    step();
    chk("idle.dout", dout, 32'h0);
    chk("idle.crst", 32'(crst), 32'h1);

    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].start, tbl[i].valid, tbl[i].last, tbl[i].data, tbl[i].ce, tbl[i].addr);
      step();
      chk($sformatf("v%0d.cnt", i),  32'(cnt),  32'(tbl[i].cnt));
      chk($sformatf("v%0d.rdy", i),  32'(ld.load_ready_o), 32'(tbl[i].rdy));
      chk($sformatf("v%0d.crst", i), 32'(crst), 32'(tbl[i].crst));
      chk($sformatf("v%0d.ovf", i),  32'(ovf),  32'(tbl[i].ovf));
      chk($sformatf("v%0d.dout", i), dout,      tbl[i].dout);
    end

    // Reset after two of four words: back to IDLE, CPU held, fetches return NOP
    drive(1, 0, 0, 32'h0, 1, 32'h0);
    step();
    drive(0, 1, 0, 32'h55550001, 1, 32'h0);
    step();
    drive(0, 1, 0, 32'h55550002, 1, 32'h0);
    step();
    chk("mid.cnt", 32'(cnt), 32'h2);
    rst = 1'b1;
    drive(1, 1, 0, 32'h55550003, 1, 32'h0);
    step();
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 1, 32'h0);
    chk("mid.rst.cnt",  32'(cnt),  32'h0);
    chk("mid.rst.rdy",  32'(ld.load_ready_o), 32'h0);
    chk("mid.rst.crst", 32'(crst), 32'h1);
    for (int a = 0; a < 4; a++) begin
      addr = 32'(a * 4);
      step();
      chk($sformatf("mid.idle.dout%0d", a), dout, 32'h0);
      chk($sformatf("mid.idle.crst%0d", a), 32'(crst), 32'h1);
    end
    drive(1, 0, 0, 32'h0, 1, 32'h4);
    step();
    for (int w = 1; w <= 4; w++) begin
      drive(0, 1, (w == 4), 32'h66660000 + 32'(w), 1, 32'h4);
      step();
    end
    chk("reload.cnt",  32'(cnt),  32'h4);
    chk("reload.rdy",  32'(ld.load_ready_o), 32'h0);
    chk("reload.crst", 32'(crst), 32'h1);
    chk("reload.dout", dout, 32'h66660002);
    drive(0, 0, 0, 32'h0, 1, 32'h0);
    step();
    chk("reload.crst1", 32'(crst), 32'h0);
    chk("reload.dout0", dout, 32'h66660001);

    // Misaligned fetch: low address bits ignored for data; flag is sticky if built
    addr = 32'h6;
    step();
    chk("mis.dout", dout, 32'h66660002);
    chk("mis.set", 32'(mis), 32'(MIS_EN));
    ce = 1'b0;
    addr = 32'h0;
    step();
    step();
    chk("mis.hold", 32'(mis), 32'(MIS_EN));
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    step();
    chk("mis.clr", 32'(mis), 32'h0);
    chk("mis.clr.crst", 32'(crst), 32'h0);
    chk("mis.clr.dout", dout, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);

    // Four-word instance: fill without last -> overflow, no wrap
    step();
    chk("ovf.rst.crst", 32'(crst2), 32'h1);
    chk("ovf.rst.ovf",  32'(ovf2),  32'h0);
    rst2 = 1'b0;
    drive2(1, 0, 0, 32'h0, 1, 32'h10);
    step();
    chk("ovf.load.rdy", 32'(ld2.load_ready_o), 32'h1);
    for (int w = 0; w < 4; w++) begin
      drive2(0, 1, 0, 32'hC0000000 + 32'(w), 1, 32'h10);
      step();
      if (w == 2) begin
        chk("ovf.w3.cnt", 32'(cnt2), 32'h3);
        chk("ovf.w3.ovf", 32'(ovf2), 32'h0);
      end
    end
    chk("ovf.cnt",  32'(cnt2), 32'h4);
    chk("ovf.flag", 32'(ovf2), 32'h1);
    chk("ovf.rdy",  32'(ld2.load_ready_o), 32'h0);
    chk("ovf.crst", 32'(crst2), 32'h1);
    drive2(0, 0, 0, 32'h0, 1, 32'h10);
    step();
    chk("ovf.oor.dout", dout2, 32'h0);
    chk("ovf.crst1", 32'(crst2), 32'h0);
    addr2 = 32'hC;
    #1;
    chk("ovf.w3.dout", dout2, 32'hC0000003);
    addr2 = 32'h0;
    #1;
    chk("ovf.w0.dout", dout2, 32'hC0000000);
    drive2(1, 0, 0, 32'h0, 1, 32'h0);
    step();
    chk("ovf.clr.flag", 32'(ovf2), 32'h0);
    chk("ovf.clr.cnt",  32'(cnt2), 32'h0);
    chk("ovf.clr.rdy",  32'(ld2.load_ready_o), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_rom_ctrl.md
INST_ROM_CTRL -- requirements
Module: inst_rom_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: log2 of storage depth in 32-bit words (DEPTH = 2**ADDR_W).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port rom_ce_i, input, 1: fetch enable from CPU.
REQ-005 SHALL have port rom_addr_i, input, 32: byte fetch address from CPU PC.
REQ-006 SHALL have port rom_data_o, output, 32: instruction word returned to CPU.
REQ-007 SHALL have port cpu_rst_o, output, 1: registered sync active-high reset to the CPU core.
REQ-008 SHALL have ports load_start_i (in, 1, begin program load), load_valid_i (in, 1), load_data_i (in, 32), load_last_i (in, 1, final word) and load_ready_o (out, 1).
REQ-009 SHALL have ports word_cnt_o (out, ADDR_W+1, words accepted this load), load_ovf_o (out, 1, sticky overflow) and fetch_misalign_o (out, 1, sticky).

Function
REQ-010 SHALL implement FSM IDLE, LOAD, RUN; reset enters IDLE.
REQ-011 SHALL go IDLE->LOAD and RUN->LOAD on load_start_i=1; the write pointer and word_cnt_o go to 0 and load_ovf_o clears.
REQ-012 SHALL, in LOAD, on load_start_i=1 restart: pointer and word_cnt_o to 0; a same-cycle load_valid_i word is dropped.
REQ-013 SHALL assert load_ready_o=1 only in LOAD; a word is accepted when load_valid_i and load_ready_o are both 1.
REQ-014 SHALL write an accepted word to mem[ptr] at the edge, increment ptr and word_cnt_o.
REQ-015 SHALL go LOAD->RUN on an accepted word with load_last_i=1.
REQ-016 SHALL go LOAD->RUN on an accepted word at ptr=DEPTH-1 with load_last_i=0, and set load_ovf_o; the pointer does not wrap.
REQ-017 SHALL drive cpu_rst_o=1 in every state except RUN; it deasserts the cycle after RUN is entered and reasserts the cycle after RUN is left.
REQ-018 SHALL drive rom_data_o combinationally, with zero latency, as mem[rom_addr_i[ADDR_W+1:2]] when state=RUN, rom_ce_i=1 and rom_addr_i[31:ADDR_W+2]=0.
REQ-019 SHALL drive rom_data_o=32'h0 (NOP) in all other cases, including out-of-range addresses and non-RUN states.
REQ-020 SHALL ignore rom_addr_i[1:0] for data selection.

Reset
REQ-021 SHALL, on rst=1, set state=IDLE, ptr=0, word_cnt_o=0, load_ovf_o=0, fetch_misalign_o=0, cpu_rst_o=1 and load_ready_o=0; rst has priority over all other inputs.
REQ-022 SHALL leave storage contents unchanged on reset, including reset mid-load; the CPU does not run until a fresh load completes.

Configuration
REQ-023 SHALL, with INST_ROM_MISALIGN_CHK_EN defined, set fetch_misalign_o when state=RUN, rom_ce_i=1 and rom_addr_i[1:0]!=0; the flag clears only on rst or load_start_i.
REQ-024 SHALL, without INST_ROM_MISALIGN_CHK_EN, tie fetch_misalign_o to 0 and synthesize no check logic.

Structure
REQ-025 SHALL take from the shared package: RegBus/InstBus width 32, InstAddrBus width 32, the NOP constant 32'h0 and the FSM state encodings.
REQ-026 SHALL instantiate one sub-module, inst_rom_mem: DEPTH x 32 array with one synchronous write port and one asynchronous read port, no reset.

Verification
REQ-027 SHALL cover: rst, load_start_i, 4 words 0x34010001..0x34010004 with last on the 4th -> word_cnt_o=4, RUN, cpu_rst_o=0 one cycle later; fetch addr 0x8 -> rom_data_o=0x34010003.
REQ-028 SHALL cover: load_valid_i toggling 1/0 over 3 words -> only handshaken words written; word_cnt_o=3.
REQ-029 SHALL cover: ADDR_W=2, 4 words with no last -> RUN after 4th word, load_ovf_o=1; fetch addr 0x10 -> rom_data_o=0.
REQ-030 SHALL cover: rst asserted after 2 of 4 words -> IDLE, cpu_rst_o=1, rom_data_o=0 for all fetches; new load then succeeds.
REQ-031 SHALL cover: in RUN, load_start_i -> cpu_rst_o=1 next cycle, rom_data_o=0, word_cnt_o=0.
REQ-032 SHALL cover, with INST_ROM_MISALIGN_CHK_EN defined: fetch addr 0x6 with ce=1 -> fetch_misalign_o=1 and stays set; without the macro -> fetch_misalign_o stays 0.
